// File: rtl/phase_frame_buffer.sv
// phase_frame_buffer: double-buffered per-channel phase/enable store.
// Host writes go to a staging bank (or the calibration bank). A commit
// request publishes staging into the active bank on the last tick of a
// PWM period, adding the per-channel calibration modulo the period, so
// every channel changes phase on the same carrier cycle.

// ---------------------------------------------------------------------------
// Per-channel slice: staging entry, calibration offset and the active
// (published) phase/enable for one transducer channel.
// ---------------------------------------------------------------------------
module phase_frame_chan #(
    parameter int CLK_CNT_W   = 8,
    parameter int CLK_CNT_MAX = 199
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stg_we,
    input  logic                 cal_we,
    input  logic [CLK_CNT_W-1:0] wr_phase,
    input  logic                 wr_en,
    input  logic                 swap,
    output logic [CLK_CNT_W-1:0] phase,
    output logic                 en
);
    localparam int                 SUM_W  = CLK_CNT_W + 1;
    localparam logic [SUM_W-1:0]   MOD    = SUM_W'(CLK_CNT_MAX + 1);
    localparam logic [CLK_CNT_W-1:0] MOD_LO = MOD[CLK_CNT_W-1:0];

    logic [CLK_CNT_W-1:0] stg_phase;
    logic                 stg_en;
    logic [CLK_CNT_W-1:0] cal;
    logic [SUM_W-1:0]     sum;
    logic [CLK_CNT_W-1:0] phase_nxt;

    // Calibrated phase: both operands are < MOD, so one conditional
    // subtract is enough. The subtract is done at CLK_CNT_W bits since the
    // wrapped result always fits there.
    always_comb begin
        sum       = {1'b0, stg_phase} + {1'b0, cal};
        phase_nxt = sum[CLK_CNT_W-1:0];
        if (sum >= MOD)
            phase_nxt = sum[CLK_CNT_W-1:0] - MOD_LO;
    end

    // Staging and calibration banks; a same-cycle write and swap leaves
    // the swap using the old contents because both read pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_phase <= '0;
            stg_en    <= 1'b0;
            cal       <= '0;
        end else begin
            if (stg_we) begin
                stg_phase <= wr_phase;
                stg_en    <= wr_en;
            end
            if (cal_we)
                cal <= wr_phase;
        end
    end

    // Active bank: only touched on a swap edge or by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            en    <= 1'b0;
        end else if (swap) begin
            phase <= phase_nxt;
            en    <= stg_en;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// Top: write qualification, commit FSM and the channel array.
// ---------------------------------------------------------------------------
module phase_frame_buffer #(
    parameter int NUM_CHANNELS = 128,
    parameter int CLK_CNT_W    = 8,
    parameter int CLK_CNT_MAX  = 199
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CLK_CNT_W-1:0]                   cnt,
    input  logic                                   wr_valid,
    input  logic                                   wr_calib,
    input  logic [$clog2(NUM_CHANNELS):0]          wr_addr,
    input  logic [CLK_CNT_W-1:0]                   wr_phase,
    input  logic                                   wr_en,
    input  logic                                   commit,
    output logic [NUM_CHANNELS-1:0][CLK_CNT_W-1:0] phases,
    output logic [NUM_CHANNELS-1:0]                pwm_en,
    output logic                                   commit_pending,
    output logic                                   commit_done,
    output logic                                   overrun,
    output logic                                   wr_err
);
    localparam int                   ADDR_W  = $clog2(NUM_CHANNELS) + 1;
    localparam logic [ADDR_W-1:0]    NCH     = ADDR_W'(NUM_CHANNELS);
    localparam logic [CLK_CNT_W-1:0] CNT_MAX = CLK_CNT_W'(CLK_CNT_MAX);

    typedef struct packed {
        logic                 calib;
        logic [ADDR_W-1:0]    addr;
        logic [CLK_CNT_W-1:0] phase;
        logic                 en;
    } wr_req_t;

    typedef enum logic [0:0] {IDLE = 1'b0, PENDING = 1'b1} state_t;

    state_t                  state;
    wr_req_t                 req;
    logic                    wr_ok;
    logic                    swap;
    logic [NUM_CHANNELS-1:0] stg_we;
    logic [NUM_CHANNELS-1:0] cal_we;

    // Bundle the write port and decide whether it is in range.
    always_comb begin
        req   = '{calib: wr_calib, addr: wr_addr, phase: wr_phase, en: wr_en};
        wr_ok = wr_valid && (req.addr < NCH) && (req.phase <= CNT_MAX);
        swap  = (state == PENDING) && (cnt == CNT_MAX);
    end

    assign commit_pending = (state == PENDING);

    // Commit FSM: one outstanding request; a commit landing on the swap
    // cycle re-arms for the next period instead of counting as overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            commit_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            commit_done <= swap;
            overrun     <= 1'b0;
            case (state)
                IDLE: begin
                    if (commit)
                        state <= PENDING;
                end
                PENDING: begin
                    if (swap)
                        state <= commit ? PENDING : IDLE;
                    else if (commit)
                        overrun <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Rejected writes are flagged one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wr_err <= 1'b0;
        else
            wr_err <= wr_valid && !wr_ok;
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
        assign stg_we[i] = wr_ok && !req.calib && (req.addr == ADDR_W'(i));
        assign cal_we[i] = wr_ok &&  req.calib && (req.addr == ADDR_W'(i));

        phase_frame_chan #(
            .CLK_CNT_W   (CLK_CNT_W),
            .CLK_CNT_MAX (CLK_CNT_MAX)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .stg_we   (stg_we[i]),
            .cal_we   (cal_we[i]),
            .wr_phase (req.phase),
            .wr_en    (req.en),
            .swap     (swap),
            .phase    (phases[i]),
            .en       (pwm_en[i])
        );
    end
endmodule

// File: tb/tb_phase_frame_buffer.sv
// Testbench for phase_frame_buffer: driver issues one cycle of stimulus per
// negedge, updates a frame-level reference model and queues the expected
// post-edge outputs; a monitor pops and compares after every posedge.
module tb_phase_frame_buffer;
    localparam int N   = 128;
    localparam int W   = 8;
    localparam int MX  = 199;
    localparam int MOD = MX + 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [W-1:0]       cnt = '0;
    logic               wr_valid = 1'b0, wr_calib = 1'b0, wr_en = 1'b0, commit = 1'b0;
    logic [7:0]         wr_addr = '0;
    logic [W-1:0]       wr_phase = '0;
    logic [N-1:0][W-1:0] phases;
    logic [N-1:0]       pwm_en;
    logic               commit_pending, commit_done, overrun, wr_err;

    phase_frame_buffer #(.NUM_CHANNELS(N), .CLK_CNT_W(W), .CLK_CNT_MAX(MX)) dut (
        .clk(clk), .rst(rst), .cnt(cnt), .wr_valid(wr_valid), .wr_calib(wr_calib),
        .wr_addr(wr_addr), .wr_phase(wr_phase), .wr_en(wr_en), .commit(commit),
        .phases(phases), .pwm_en(pwm_en), .commit_pending(commit_pending),
        .commit_done(commit_done), .overrun(overrun), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]          st;   // {done, overrun, wr_err, pending}
        logic [N-1:0][W-1:0] ph;
        logic [N-1:0]        en;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   started = 0;
    int   cyc = 0;

    // Reference model: frame-level banks as plain integer arrays.
    int stg_ph[N], stg_en[N], cal[N], act_ph[N], act_en[N];
    bit pend;
    int cur_cnt = 0;

    function automatic exp_t snapshot(input bit d, input bit o, input bit e, input bit p);
        exp_t x;
        x.st = {d, o, e, p};
        for (int i = 0; i < N; i++) begin
            x.ph[i] = W'(act_ph[i]);
            x.en[i] = act_en[i][0];
        end
        return x;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            stg_ph[i] = 0; stg_en[i] = 0; cal[i] = 0; act_ph[i] = 0; act_en[i] = 0;
        end
        pend = 0;
    endfunction

    // One clock of stimulus plus the model's view of the following edge.
    task automatic tick(input bit v, input bit c, input int a, input int p,
                        input bit e, input bit cm, input bit r);
        bit ok, sw, d, o, er;
        @(negedge clk);
        wr_valid = v; wr_calib = c; wr_addr = 8'(a); wr_phase = W'(p);
        wr_en = e; commit = cm; cnt = W'(cur_cnt); rst = r;
        started = 1;
        if (r) begin
            #1;
            n_vec++;
            if (phases !== '0 || pwm_en !== '0 || commit_pending !== 1'b0 ||
                commit_done !== 1'b0 || overrun !== 1'b0 || wr_err !== 1'b0) begin
                n_err++;
                $display("FAIL async_reset t=%0t pend=%b done=%b ovr=%b err=%b en_nz=%b ph_nz=%b, all required 0",
                         $time, commit_pending, commit_done, overrun, wr_err, |pwm_en, |phases);
            end
            model_reset();
            sb.push_back(snapshot(0, 0, 0, 0));
        end else begin
            ok = v && (a < N) && (p <= MX);
            sw = pend && (cur_cnt == MX);
            if (sw)
                for (int i = 0; i < N; i++) begin
                    act_ph[i] = (stg_ph[i] + cal[i]) % MOD;
                    act_en[i] = stg_en[i];
                end
            d  = sw;
            o  = pend && cm && !sw;
            er = v && !ok;
            pend = pend ? (sw ? cm : 1'b1) : cm;
            if (ok) begin
                if (c) cal[a] = p;
                else begin stg_ph[a] = p; stg_en[a] = int'(e); end
            end
            sb.push_back(snapshot(d, o, er, pend));
        end
        cur_cnt = (cur_cnt == MX) ? 0 : cur_cnt + 1;
    endtask

    task automatic idle(); tick(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic run_to(input int c); while (cur_cnt != c) idle(); endtask
    task automatic run_n(input int n); for (int k = 0; k < n; k++) idle(); endtask

    // Monitor: every cycle's outputs against the queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!started) continue;
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL scoreboard_empty cyc=%0d", cyc);
                continue;
            end
            x = sb.pop_front();
            n_vec++;
            if ({commit_done, overrun, wr_err, commit_pending} !== x.st) begin
                n_err++;
                $display("FAIL status cyc=%0d cnt_prev=%0d got{done,ovr,err,pend}=%b exp=%b",
                         cyc, (cnt), {commit_done, overrun, wr_err, commit_pending}, x.st);
            end
            n_vec++;
            if (phases !== x.ph || pwm_en !== x.en) begin
                n_err++;
                for (int i = 0; i < N; i++)
                    if (phases[i] !== x.ph[i] || pwm_en[i] !== x.en[i]) begin
                        $display("FAIL active_bank cyc=%0d ch=%0d got ph=%0d en=%b exp ph=%0d en=%b",
                                 cyc, i, phases[i], pwm_en[i], x.ph[i], x.en[i]);
                        break;
                    end
            end
        end
    end

    initial begin
        model_reset();
        tick(0, 0, 0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 0, 0, 1);
        cur_cnt = 0;
        // Free run, nothing published.
        run_n(205);
        // ch5 50 + 30, commit at cnt 10.
        run_to(0);
        tick(1, 0, 5, 50, 1, 0, 0);
        tick(1, 1, 5, 30, 0, 0, 0);
        run_to(10);
        tick(0, 0, 0, 0, 0, 1, 0);
        run_to(1);
        run_n(3);
        // Wrap and edge values.
        tick(1, 0, 7, 180, 1, 0, 0);
        tick(1, 1, 7, 40, 0, 0, 0);
        tick(1, 0, 8, 199, 1, 0, 0);
        tick(1, 1, 8, 0, 0, 0, 0);
        tick(1, 0, 9, 0, 1, 0, 0);
        tick(1, 1, 9, 0, 0, 0, 0);
        tick(1, 1, 10, 199, 0, 0, 0);
        tick(1, 0, 10, 199, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 0);
        run_to(2);
        // Overrun: commits at 20 and 60.
        run_to(20); tick(0, 0, 0, 0, 0, 1, 0);
        tick(1, 0, 11, 123, 1, 0, 0);
        run_to(60); tick(0, 0, 0, 0, 0, 1, 0);
        run_to(2);
        // Commit exactly on the swap cycle while pending.
        tick(1, 0, 12, 44, 1, 0, 0);
        run_to(20); tick(0, 0, 0, 0, 0, 1, 0);
        tick(1, 0, 13, 66, 1, 0, 0);
        run_to(199); tick(0, 0, 0, 0, 0, 1, 0);
        tick(1, 0, 14, 88, 1, 0, 0);
        run_to(2);
        // Commit on cnt 199 while idle: no swap until a period later.
        run_to(199); tick(1, 0, 15, 11, 1, 1, 0);
        run_to(2);
        // Write landing in the swap cycle.
        run_to(50); tick(0, 0, 0, 0, 0, 1, 0);
        run_to(199); tick(1, 0, 3, 77, 1, 0, 0);
        run_n(5);
        tick(0, 0, 0, 0, 0, 1, 0);
        run_to(2);
        // Rejected writes, then re-commit.
        tick(1, 0, 128, 10, 1, 0, 0);
        tick(1, 1, 128, 10, 0, 0, 0);
        tick(1, 0, 4, 200, 1, 0, 0);
        tick(1, 1, 4, 255, 0, 0, 0);
        tick(1, 0, 255, 5, 1, 0, 0);
        tick(0, 0, 0, 0, 0, 1, 0);
        run_to(2);
        // Reset while pending.
        run_to(30); tick(0, 0, 0, 0, 0, 1, 0);
        run_to(90);
        tick(0, 0, 0, 0, 0, 0, 1);
        run_to(5);
        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            int  a, p;
            bit  v, c, e, cm, r;
            v  = ($urandom_range(0, 1) == 1);
            c  = ($urandom_range(0, 3) == 0);
            a  = $urandom_range(0, 140);
            p  = $urandom_range(0, 210);
            e  = $urandom_range(0, 1);
            cm = ($urandom_range(0, 120) == 0) || ((cur_cnt == MX) && ($urandom_range(0, 3) == 0));
            r  = ($urandom_range(0, 1500) == 0);
            tick(v, c, a, p, e, cm, r);
        end
        run_n(3);
        @(posedge clk);
        #3;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain left=%0d required=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
